// File: rtl/issue_rename.sv
// rtl/issue_rename.sv - issue stage: register file, rename-status table, RS issue register
module issue_rename #(
  parameter int          OP_W      = 6,
  parameter logic [31:0] READY_TAG = 32'hFFFF_FFFF
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            clear,
  input  logic            RS_is_full,
  input  logic            issue_en,
  input  logic [OP_W-1:0] issue_op,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic [4:0]      issue_rd,
  input  logic            issue_rd_we,
  input  logic [4:0]      issue_rob,
  output logic            issue_ready,
  input  logic            commit_en,
  input  logic [4:0]      commit_Number,
  input  logic [31:0]     commit_val,
  input  logic [4:0]      commit_rd,
  input  logic            commit_rd_we,
  output logic            RS_in,
  output logic [4:0]      ROB_Number,
  output logic [OP_W-1:0] OpCode_RS,
  output logic [31:0]     Reg_Status_1_RS,
  output logic [31:0]     Reg_Status_2_RS,
  output logic [31:0]     Reg_Data_1_RS,
  output logic [31:0]     Reg_Data_2_RS
);

  // architectural values and rename status (READY_TAG or zero-extended ROB tag)
  logic [31:0] reg_val  [32];
  logic [31:0] reg_stat [32];

  logic        accept;
  logic        rename;
  logic        commit_write;
  logic        commit_clears;
  logic [31:0] commit_tag;
  logic [31:0] op1_stat, op1_data;
  logic [31:0] op2_stat, op2_data;

  // resolve one source against pre-update state, with same-cycle commit forwarding
  function automatic logic [63:0] resolve(
    input logic [4:0]  rs,
    input logic [31:0] stat,
    input logic [31:0] val,
    input logic        c_en,
    input logic [31:0] c_tag,
    input logic [31:0] c_val
  );
    logic [63:0] r;
    if (rs == 5'd0)
      r = {READY_TAG, 32'd0};
    else if (stat == READY_TAG)
      r = {READY_TAG, val};
    else if (c_en && (c_tag == stat))
      r = {READY_TAG, c_val};
    else
      r = {stat, 32'd0};
    return r;
  endfunction

  // handshake and update qualifiers
  always_comb begin
    issue_ready   = !RS_is_full && !clear;
    accept        = rdy_in && !rst_in && !clear && issue_en && issue_ready;
    rename        = accept && issue_rd_we && (issue_rd != 5'd0);
    commit_tag    = {27'd0, commit_Number};
    commit_write  = commit_en && commit_rd_we && (commit_rd != 5'd0);
    commit_clears = commit_write && (reg_stat[commit_rd] == commit_tag);
  end

  // operand resolution for both sources; a self-dependency sees the previous producer
  always_comb begin
    {op1_stat, op1_data} = resolve(issue_rs1, reg_stat[issue_rs1], reg_val[issue_rs1],
                                   commit_en, commit_tag, commit_val);
    {op2_stat, op2_data} = resolve(issue_rs2, reg_stat[issue_rs2], reg_val[issue_rs2],
                                   commit_en, commit_tag, commit_val);
  end

  // register file and status table; a same-cycle rename overrides the commit's status release
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        reg_val[i]  <= 32'd0;
        reg_stat[i] <= READY_TAG;
      end
    end else if (rdy_in) begin
      if (commit_write) begin
        reg_val[commit_rd] <= commit_val;
        if (commit_clears)
          reg_stat[commit_rd] <= READY_TAG;
      end
      if (clear) begin
        for (int i = 0; i < 32; i++)
          reg_stat[i] <= READY_TAG;
      end else if (rename) begin
        reg_stat[issue_rd] <= {27'd0, issue_rob};
      end
    end
  end

  // one-cycle issue pulse; data fields only load on accept and otherwise hold
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      RS_in           <= 1'b0;
      ROB_Number      <= 5'd0;
      OpCode_RS       <= '0;
      Reg_Status_1_RS <= 32'd0;
      Reg_Status_2_RS <= 32'd0;
      Reg_Data_1_RS   <= 32'd0;
      Reg_Data_2_RS   <= 32'd0;
    end else if (rdy_in) begin
      RS_in <= accept;
      if (accept) begin
        ROB_Number      <= issue_rob;
        OpCode_RS       <= issue_op;
        Reg_Status_1_RS <= op1_stat;
        Reg_Status_2_RS <= op2_stat;
        Reg_Data_1_RS   <= op1_data;
        Reg_Data_2_RS   <= op2_data;
      end
    end
  end

endmodule
